// File: rtl/fp_int2fp_converter.sv
// Converts a 13-bit two's-complement integer to a sign/exp/frac float word.
// Latency: k+3 cycles from accept to o_valid (k = normalisation shifts); 1 cycle for zero.
// Backpressure: single conversion in flight, o_ready only in IDLE; o_fp held in DONE until i_ready.
module fp_int2fp_converter (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [12:0] i_int,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [12:0] o_fp
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] NORM  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state;
    logic [12:0] mag;
    logic [3:0]  exp;
    logic        sign;

    // Magnitude of the incoming integer; -4096 maps to 0x1000, which still fits 13 bits.
    logic [12:0] mag_in;
    assign mag_in = i_int[12] ? (~i_int + 13'd1) : i_int;

    // Round-to-nearest-even on the normalised magnitude.
    logic [7:0] frac_raw;
    logic       guard;
    logic       sticky;
    logic       round_up;
    logic [8:0] frac_sum;
    logic       frac_ovf;
    logic [7:0] frac_rnd;
    logic [3:0] exp_rnd;

    // Rounding datapath, only consumed in ROUND.
    always_comb begin
        frac_raw = mag[12:5];
        guard    = mag[4];
        sticky   = |mag[3:0];
        round_up = guard & (sticky | frac_raw[0]);
        frac_sum = {1'b0, frac_raw} + {8'd0, round_up};
        frac_ovf = frac_sum[8];
        frac_rnd = frac_ovf ? 8'h80 : frac_sum[7:0];
        exp_rnd  = exp + {3'd0, frac_ovf};
    end

    // Handshake flags are pure decodes of the state register.
    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

    // Conversion FSM: capture, normalise one bit per cycle, round, then hold for downstream.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            mag   <= 13'd0;
            exp   <= 4'd0;
            sign  <= 1'b0;
            o_fp  <= 13'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        mag <= mag_in;
                        exp <= 4'd13;
                        if (mag_in == 13'd0) begin
                            sign  <= 1'b0;
                            o_fp  <= 13'd0;
                            state <= DONE;
                        end else begin
                            sign  <= i_int[12];
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mag[12]) begin
                        state <= ROUND;
                    end else begin
                        mag <= {mag[11:0], 1'b0};
                        exp <= exp - 4'd1;
                    end
                end
                ROUND: begin
                    o_fp  <= {sign, exp_rnd, frac_rnd};
                    state <= DONE;
                end
                DONE: begin
                    if (i_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_int2fp_converter.sv
// Scoreboarded bench for fp_int2fp_converter: directed corner values, random stream,
// backpressure hold and mid-conversion reset, checked against an arithmetic model.
module tb_fp_int2fp_converter;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [12:0] i_int;
    logic        o_valid;
    logic        i_ready;
    logic [12:0] o_fp;

    fp_int2fp_converter dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_int   (i_int),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_fp    (o_fp)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [12:0] fp;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   rand_rdy = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Reference: value = 0.frac * 2^e with frac rounded to 8 bits, ties to even.
    task automatic ref_conv(input logic [12:0] v, output logic [12:0] fp, output int lat);
        int x, m, e, q, sh, r, h, k;
        bit s;
        x = $signed(v);
        s = (x < 0);
        m = s ? -x : x;
        if (m == 0) begin
            fp  = 13'd0;
            lat = 1;
        end else begin
            e = 0;
            while ((1 << e) <= m) e++;
            k = 13 - e;
            if (e > 8) begin
                sh = e - 8;
                q  = m >> sh;
                r  = m - (q << sh);
                h  = 1 << (sh - 1);
                if (r > h || (r == h && (q % 2) == 1)) q++;
            end else begin
                q = m << (8 - e);
            end
            if (q == 256) begin
                q = 128;
                e++;
            end
            fp  = {s, 4'(e), 8'(q)};
            lat = k + 3;
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares outputs against the scoreboard and handshake rules every cycle.
    logic        prev_vld = 1'b0;
    logic        prev_rdy = 1'b0;
    logic [12:0] prev_fp  = 13'd0;
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            chk("rst_ready", int'(o_ready), 1);
            chk("rst_valid", int'(o_valid), 0);
            chk("rst_fp", int'(o_fp), 0);
            sbq.delete();
            prev_vld = 1'b0;
        end else begin
            if (prev_vld) begin
                chk("hold_or_release", int'(o_valid), int'(!prev_rdy));
                if (!o_valid) chk("idle_after_done", int'(o_ready), 1);
            end
            if (o_valid) begin
                chk("done_not_ready", int'(o_ready), 0);
                if (!prev_vld) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("result_fp", int'(o_fp), int'(e.fp));
                        chk("latency_cycle", cyc, e.cyc);
                    end
                end else begin
                    chk("fp_stable", int'(o_fp), int'(prev_fp));
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
                chk("result_timeout", cyc, sbq[0].cyc);
                void'(sbq.pop_front());
            end
            prev_vld = o_valid;
            prev_fp  = o_fp;
            prev_rdy = i_ready;
        end
    end

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge i_clk);
        #1;
        if (rand_rdy) i_ready = ($urandom_range(0, 2) != 0);
        if (!o_ready) begin
            i_valid = 1'($urandom_range(0, 1));
            i_int   = 13'($urandom);
        end else begin
            i_valid = 1'b0;
        end
    endtask

    task automatic issue(input logic [12:0] v);
        logic [12:0] fp;
        int          lat;
        exp_t        e;
        for (int n = 0; n < 200 && !o_ready; n++) step();
        if (o_ready) begin
            ref_conv(v, fp, lat);
            e.fp  = fp;
            e.cyc = cyc + lat;
            sbq.push_back(e);
            i_valid = 1'b1;
            i_int   = v;
            step();
        end
    endtask

    initial begin
        logic [12:0] dir[7];
        dir[0] = 13'h0001; dir[1] = 13'h1FFF; dir[2] = 13'h1000; dir[3] = 13'h0FFF;
        dir[4] = 13'h0000; dir[5] = 13'h0189; dir[6] = 13'h018B;

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_int   = 13'd0;
        i_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        foreach (dir[i]) issue(dir[i]);

        // Backpressure: result must stay put while downstream stalls.
        i_ready = 1'b0;
        issue(13'h0189);
        for (int n = 0; n < 40 && !o_valid; n++) step();
        repeat (5) step();
        i_ready = 1'b1;
        repeat (2) step();

        // Reset in the middle of normalisation, then a fresh conversion right after release.
        issue(13'h0001);
        repeat (4) step();
        i_rst_n = 1'b0;
        repeat (2) step();
        i_rst_n = 1'b1;
        issue(13'h0002);

        // Random stream with random downstream readiness.
        rand_rdy = 1;
        for (int n = 0; n < 200; n++) issue(13'($urandom));
        rand_rdy = 0;
        i_ready  = 1'b1;
        for (int n = 0; n < 100 && (sbq.size() > 0 || o_valid); n++) step();
        repeat (2) step();
        if (sbq.size() > 0) chk("drain_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
